// File: rtl/if_fetch_pkg.sv
// Shared constants for the mipslite instruction-fetch stage: datapath width,
// reset fetch address, the NOP bubble value and the fetch FSM encodings.
package if_fetch_pkg;

    localparam int LENGTH = 32;

    localparam logic [LENGTH-1:0] DEFAULT_RESET_PC = 32'h0000_3000;

    // Value driven on inst_out whenever no real instruction is presented.
    localparam logic [LENGTH-1:0] INITIAL_VAL = '0;

    // Fetch FSM encodings.
    localparam logic [1:0] S_BOOT    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_DISCARD = 2'd2;
    localparam logic [1:0] S_HOLD    = 2'd3;

    // Instruction addresses are word aligned; the low two bits are dropped.
    function automatic logic [LENGTH-1:0] word_align(input logic [LENGTH-1:0] addr);
        return {addr[LENGTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues one outstanding request at a
// time to instruction memory, and buffers one returned instruction until the
// IF/ID register takes it. Redirects are accepted in every state; a redirect
// that arrives while a request is in flight lets that request finish and
// throws its data away.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [LENGTH-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [LENGTH-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [LENGTH-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [LENGTH-1:0] redirect_pc,
    input  logic              stall,
    output logic [LENGTH-1:0] inst_out,
    output logic [LENGTH-1:0] pc_4_out,
    output logic              inst_valid
);

    logic [1:0]        state;
    logic [LENGTH-1:0] pc;
    logic [LENGTH-1:0] target;
    logic [LENGTH-1:0] pc_plus4;
    logic [LENGTH-1:0] addr_plus4;

    // Aligned redirect target and the two modulo-2^32 increments.
    always_comb begin
        target     = word_align(redirect_pc);
        pc_plus4   = pc + LENGTH'(4);
        addr_plus4 = imem_addr + LENGTH'(4);
    end

    // Fetch FSM; every output is a flop, and imem_req is high exactly in
    // S_REQ and S_DISCARD.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            state      <= S_BOOT;
            pc         <= RESET_PC;
            imem_req   <= 1'b0;
            imem_addr  <= RESET_PC;
            inst_out   <= INITIAL_VAL;
            pc_4_out   <= '0;
            inst_valid <= 1'b0;
        end else begin
            case (state)
                S_BOOT: begin
                    // A stray ack left over from before reset is ignored here.
                    state    <= S_REQ;
                    imem_req <= 1'b1;
                    if (redirect) begin
                        pc        <= target;
                        imem_addr <= target;
                    end else begin
                        imem_addr <= pc;
                    end
                end

                S_REQ: begin
                    if (redirect) begin
                        pc <= target;
                        if (imem_ack) begin
                            // Returned word belongs to the old path; refetch.
                            imem_addr <= target;
                        end else begin
                            // Request must still complete at its old address.
                            state <= S_DISCARD;
                        end
                    end else if (imem_ack) begin
                        inst_out   <= imem_rdata;
                        pc_4_out   <= addr_plus4;
                        inst_valid <= 1'b1;
                        pc         <= pc_plus4;
                        imem_req   <= 1'b0;
                        state      <= S_HOLD;
                    end
                end

                S_DISCARD: begin
                    if (redirect) begin
                        pc <= target;
                    end
                    if (imem_ack) begin
                        imem_addr <= redirect ? target : pc;
                        state     <= S_REQ;
                    end
                end

                S_HOLD: begin
                    if (redirect) begin
                        inst_valid <= 1'b0;
                        inst_out   <= INITIAL_VAL;
                        pc         <= target;
                        imem_addr  <= target;
                        imem_req   <= 1'b1;
                        state      <= S_REQ;
                    end else if (!stall) begin
                        inst_valid <= 1'b0;
                        inst_out   <= INITIAL_VAL;
                        imem_addr  <= pc;
                        imem_req   <= 1'b1;
                        state      <= S_REQ;
                    end
                end

                default: begin
                    state    <= S_BOOT;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
